dmem_ctrl: RTL and testbench

//  Data-memory controller directly downstream of the core's EM/WB memory port.

---
 rtl/dmem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller: byte-lane RAM, MMIO TX FIFO, aligned loads/stores
// Optional misaligned-store trap: define DMEM_MISALIGN_CHK_EN.

module dmem_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  output logic [7:0]               m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign s_tready = (count != CW'(DEPTH));
  assign m_tvalid = (count != '0);
  assign m_tdata  = mem[rd_ptr];
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end
endmodule

module dmem_ctrl #(
  parameter int          RAM_AW    = 12,
  parameter int          TX_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_oe,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        misalign_err
);
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]      ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic [TX_CW-1:0] tx_count;
  logic             tx_s_tready;
  logic             tx_push;
  logic             is_mmio;
  logic             txdata_hit;
  logic             status_hit;
  logic             accept;
  logic             load;
  logic             store;
  logic             misalign;
  logic             store_ok;
  logic [3:0]       we_sh;
  logic [31:0]      wd_sh;
  logic [31:0]      status_word;
  logic [31:0]      rd_word;

  assign ram_idx    = mem_addr[RAM_AW+1:2];
  assign is_mmio    = mem_addr[31];
  assign txdata_hit = (mem_addr == MMIO_BASE);
  assign status_hit = ({mem_addr[31:2], 2'b00} == MMIO_BASE + 32'd4);

  // Back-pressure depends only on the address and FIFO state, never on the strobes.
  assign mem_ready = !(txdata_hit && !tx_s_tready);

  assign accept = mem_oe & mem_ready;
  assign load   = accept & (mem_we == 4'b0000);
  assign store  = accept & (mem_we != 4'b0000);

  assign we_sh = mem_we << mem_addr[1:0];
  assign wd_sh = mem_wdata << {mem_addr[1:0], 3'b000};

  always_comb begin
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    misalign = ((mem_we == 4'b0011) && mem_addr[0]) ||
               ((mem_we == 4'b1111) && (mem_addr[1:0] != 2'b00));
`endif
  end

  assign store_ok = store & ~misalign;
  assign tx_push  = store_ok & txdata_hit;

  assign status_word = {{(30-TX_CW){1'b0}}, tx_count, ~tx_valid, ~tx_s_tready};

  always_comb begin
    rd_word = 32'd0;
    if (!is_mmio)
      rd_word = ram[ram_idx];
    else if (status_hit)
      rd_word = status_word;
  end

  always_ff @(posedge clk) begin
    if (store_ok && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (we_sh[i]) ram[ram_idx][8*i +: 8] <= wd_sh[8*i +: 8];
      end
    end
  end

  // Load data is right-aligned at issue so WB can extend from bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      mem_valid <= load;
      if (load) mem_rdata <= rd_word >> {mem_addr[1:0], 3'b000};
    end
  end

`ifdef DMEM_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign_err <= 1'b0;
    else if (store && misalign)
      misalign_err <= 1'b1;
  end
`else
  assign misalign_err = 1'b0;
`endif

  dmem_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (mem_wdata[7:0]),
    .s_tvalid (tx_push),
    .s_tready (tx_s_tready),
    .m_tdata  (tx_data),
    .m_tvalid (tx_valid),
    .m_tready (tx_ready),
    .count    (tx_count)
  );
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl (loads, lanes, MMIO FIFO, reset, misalign)

module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_oe;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        misalign_err;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] sb  [$];
  logic [7:0]  txq [$];

  localparam logic [31:0] TXD = 32'h8000_0000;
  localparam logic [31:0] STS = 32'h8000_0004;

  dmem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_oe       (mem_oe),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one access for one cycle and returns at the next negedge.
  task automatic access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                        input logic exp_rdy, input logic [31:0] exp_rd);
    mem_addr  = addr;
    mem_we    = we;
    mem_wdata = wd;
    mem_oe    = 1'b1;
    #1 check("mem_ready", {31'd0, mem_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    if (exp_rdy && we == 4'b0000) sb.push_back(exp_rd);
    if (exp_rdy && we != 4'b0000 && addr == TXD) txq.push_back(wd[7:0]);
    @(negedge clk);
    mem_oe = 1'b0;
    mem_we = 4'b0000;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0) begin
        logic [31:0] exp;
        exp = sb.pop_front();
        check("load_valid", {31'd0, mem_valid}, 32'd1);
        check("load_rdata", mem_rdata, exp);
      end else begin
        check("no_spurious_valid", {31'd0, mem_valid}, 32'd0);
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; mem_addr = 32'd0; mem_oe = 1'b0; mem_wdata = 32'd0; mem_we = 4'd0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_ready", {31'd0, mem_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    access(32'h10, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0);
    access(32'h10, 4'b0000, 32'h0, 1'b1, 32'hDEADBEEF);
    access(32'h13, 4'b0001, 32'h000000A5, 1'b1, 32'h0);
    access(32'h10, 4'b0000, 32'h0, 1'b1, 32'hA5ADBEEF);
    access(32'h13, 4'b0000, 32'h0, 1'b1, 32'h000000A5);
    access(32'h12, 4'b0000, 32'h0, 1'b1, 32'h0000A5AD);
    access(32'h16, 4'b0011, 32'h0000CAFE, 1'b1, 32'h0);
    access(32'h16, 4'b0000, 32'h0, 1'b1, 32'h0000CAFE);
    access(32'h4010, 4'b0000, 32'h0, 1'b1, 32'hA5ADBEEF);
    access(STS, 4'b0000, 32'h0, 1'b1, 32'h0000_0002);
    access(TXD, 4'b0000, 32'h0, 1'b1, 32'h0);
    access(32'h8000_0008, 4'b0000, 32'h0, 1'b1, 32'h0);
    access(STS, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'h0);

    for (int i = 0; i < 8; i++) access(TXD, 4'b0001, 32'h10 + i, 1'b1, 32'h0);
    access(TXD, 4'b0001, 32'hEE, 1'b0, 32'h0);
    access(STS, 4'b0000, 32'h0, 1'b1, 32'h0000_0021);
    check("tx_valid_full", {31'd0, tx_valid}, 32'd1);

    mem_addr = TXD;
    tx_ready = 1'b1;
    check("tx_head", {24'd0, tx_data}, {24'd0, txq[0]});
    #1 check("ready_while_full", {31'd0, mem_ready}, 32'd0);
    @(posedge clk);
    void'(txq.pop_front());
    @(negedge clk);
    tx_ready = 1'b0;
    access(TXD, 4'b0001, 32'h99, 1'b1, 32'h0);

    tx_ready = 1'b1;
    guard = 0;
    while (txq.size() > 0 && guard < 40) begin
      check("drain_valid", {31'd0, tx_valid}, 32'd1);
      check("drain_data", {24'd0, tx_data}, {24'd0, txq.pop_front()});
      @(negedge clk);
      guard++;
    end
    check("drain_bounded", txq.size(), 32'd0);
    check("drain_empty", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    access(STS, 4'b0000, 32'h0, 1'b1, 32'h0000_0002);

    access(TXD, 4'b0001, 32'h42, 1'b1, 32'h0);
    mem_addr = 32'h10; mem_we = 4'b0000; mem_oe = 1'b1;
    @(posedge clk);
    sb.push_back(32'hA5ADBEEF);
    #2 rst = 1'b1;
    sb.delete();
    txq.delete();
    #1;
    check("midrst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    mem_oe = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_tx_valid", {31'd0, tx_valid}, 32'd0);

    access(32'h12, 4'b1111, 32'h11223344, 1'b1, 32'h0);
`ifdef DMEM_MISALIGN_CHK_EN
    check("misalign_err", {31'd0, misalign_err}, 32'd1);
    access(32'h10, 4'b0000, 32'h0, 1'b1, 32'hA5ADBEEF);
`else
    check("misalign_err", {31'd0, misalign_err}, 32'd0);
    access(32'h10, 4'b0000, 32'h0, 1'b1, 32'h3344BEEF);
`endif
    @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
